// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus data-memory pin bundle for mem_access_unit.
// slave = the sequencer; master = pipeline requester and memory model side.
interface mem_access_unit_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) ();
    logic              req_vld;
    logic              req_rdy;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_se;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdat;

    logic              rsp_vld;
    logic              rsp_rdy;
    logic [DATA_W-1:0] rsp_rdat;
    logic              rsp_fault;

    logic              mem_enable;
    logic              mem_read_write;
    logic              mem_se;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    modport slave (
        input  req_vld, req_write, req_size, req_se, req_addr, req_wdat,
        output req_rdy,
        output rsp_vld, rsp_rdat, rsp_fault,
        input  rsp_rdy,
        output mem_enable, mem_read_write, mem_se, mem_size, mem_address, mem_data_in,
        input  mem_data_out
    );

    modport master (
        output req_vld, req_write, req_size, req_se, req_addr, req_wdat,
        input  req_rdy,
        input  rsp_vld, rsp_rdat, rsp_fault,
        output rsp_rdy,
        input  mem_enable, mem_read_write, mem_se, mem_size, mem_address, mem_data_in,
        output mem_data_out
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of the byte-addressed data memory; one access in flight.
// Latency: fault T+1, store T+2, load T+READ_LAT+1; req_rdy only in IDLE, response held until rsp_rdy.
module mem_access_unit #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    mem_access_unit_if.slave  bus_io
);

    localparam int              CNT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_rw_q,    mem_rw_d;
    logic              mem_se_q,    mem_se_d;
    logic [1:0]        mem_size_q,  mem_size_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdat_q,  mem_wdat_d;
    logic [DATA_W-1:0] rsp_rdat_q,  rsp_rdat_d;
    logic              rsp_fault_q, rsp_fault_d;

    logic              req_fault;

    // Halfwords need an even address; words (size 10 and 11) need a 4-byte aligned one.
    assign req_fault = ((bus_io.req_size == 2'b01) & bus_io.req_addr[0])
                     | (bus_io.req_size[1] & (bus_io.req_addr[1:0] != 2'b00));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_se_q    <= 1'b0;
            mem_size_q  <= 2'b00;
            mem_addr_q  <= '0;
            mem_wdat_q  <= '0;
            rsp_rdat_q  <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_rw_q    <= mem_rw_d;
            mem_se_q    <= mem_se_d;
            mem_size_q  <= mem_size_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdat_q  <= mem_wdat_d;
            rsp_rdat_q  <= rsp_rdat_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_en_d    = mem_en_q;
        mem_rw_d    = mem_rw_q;
        mem_se_d    = mem_se_q;
        mem_size_d  = mem_size_q;
        mem_addr_d  = mem_addr_q;
        mem_wdat_d  = mem_wdat_q;
        rsp_rdat_d  = rsp_rdat_q;
        rsp_fault_d = rsp_fault_q;

        unique case (state_q)
            IDLE: begin
                if (bus_io.req_vld) begin
                    if (req_fault) begin
                        // Misaligned: answer directly, memory pins keep their old values.
                        state_d     = RESP;
                        rsp_fault_d = 1'b1;
                        rsp_rdat_d  = '0;
                    end else begin
                        state_d    = ACCESS;
                        cnt_d      = '0;
                        mem_en_d   = 1'b1;
                        mem_rw_d   = bus_io.req_write;
                        mem_se_d   = bus_io.req_se;
                        mem_size_d = bus_io.req_size;
                        mem_addr_d = bus_io.req_addr;
                        mem_wdat_d = bus_io.req_wdat;
                    end
                end
            end

            ACCESS: begin
                if (mem_rw_q) begin
                    state_d    = RESP;
                    mem_en_d   = 1'b0;
                    mem_rw_d   = 1'b0;
                    rsp_rdat_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = RESP;
                    mem_en_d   = 1'b0;
                    cnt_d      = '0;
                    rsp_rdat_d = bus_io.mem_data_out;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RESP: begin
                if (bus_io.rsp_rdy) begin
                    state_d     = IDLE;
                    rsp_rdat_d  = '0;
                    rsp_fault_d = 1'b0;
                end
            end

            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
                mem_rw_d = 1'b0;
            end
        endcase
    end

    assign bus_io.req_rdy        = (state_q == IDLE);
    assign bus_io.rsp_vld        = (state_q == RESP);
    assign bus_io.rsp_rdat       = rsp_rdat_q;
    assign bus_io.rsp_fault      = rsp_fault_q;
    assign bus_io.mem_enable     = mem_en_q;
    assign bus_io.mem_read_write = mem_rw_q;
    assign bus_io.mem_se         = mem_se_q;
    assign bus_io.mem_size       = mem_size_q;
    assign bus_io.mem_address    = mem_addr_q;
    assign bus_io.mem_data_in    = mem_wdat_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: READ_LAT=1 and READ_LAT=3 instances share one stimulus port and a pin-level memory.
// Randomized transactions are scored against a transaction-level byte image of the memory.
module tb_mem_access_unit;

    localparam int AW = 9;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          sel;
    logic          req_vld, req_write, req_se, rsp_rdy;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdat;

    mem_access_unit_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();
    mem_access_unit_if #(.ADDR_W(AW), .DATA_W(DW)) if3 ();

    mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .bus_io(if1.slave));
    mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .bus_io(if3.slave));

    assign if1.req_vld   = req_vld & ~sel;
    assign if3.req_vld   = req_vld &  sel;
    assign if1.rsp_rdy   = rsp_rdy & ~sel;
    assign if3.rsp_rdy   = rsp_rdy &  sel;
    assign if1.req_write = req_write;  assign if3.req_write = req_write;
    assign if1.req_size  = req_size;   assign if3.req_size  = req_size;
    assign if1.req_se    = req_se;     assign if3.req_se    = req_se;
    assign if1.req_addr  = req_addr;   assign if3.req_addr  = req_addr;
    assign if1.req_wdat  = req_wdat;   assign if3.req_wdat  = req_wdat;

    // Observed outputs of the currently selected instance
    logic          o_req_rdy, o_rsp_vld, o_rsp_fault, m_en, m_rw, m_se;
    logic [DW-1:0] o_rsp_rdat, m_wdat, mem_q;
    logic [1:0]    m_size;
    logic [AW-1:0] m_addr;
    int            cur_lat;

    assign o_req_rdy   = sel ? if3.req_rdy        : if1.req_rdy;
    assign o_rsp_vld   = sel ? if3.rsp_vld        : if1.rsp_vld;
    assign o_rsp_rdat  = sel ? if3.rsp_rdat       : if1.rsp_rdat;
    assign o_rsp_fault = sel ? if3.rsp_fault      : if1.rsp_fault;
    assign m_en        = sel ? if3.mem_enable     : if1.mem_enable;
    assign m_rw        = sel ? if3.mem_read_write : if1.mem_read_write;
    assign m_se        = sel ? if3.mem_se         : if1.mem_se;
    assign m_size      = sel ? if3.mem_size       : if1.mem_size;
    assign m_addr      = sel ? if3.mem_address    : if1.mem_address;
    assign m_wdat      = sel ? if3.mem_data_in    : if1.mem_data_in;
    assign cur_lat     = sel ? 3 : 1;
    assign if1.mem_data_out = mem_q;
    assign if3.mem_data_out = mem_q;

    // Pin-level data memory: data is only valid in the last cycle of the read window.
    logic [7:0]    pin_mem [512] = '{default: 8'h00};
    int            en_run = 0;
    int            cyc = 0;
    int            stab_errs = 0;
    logic          prev_en = 1'b0;
    logic [45:0]   prev_bus = '0;
    logic [AW-1:0] a1, a2, a3;
    logic [DW-1:0] raw;

    assign a1  = m_addr + 9'd1;
    assign a2  = m_addr + 9'd2;
    assign a3  = m_addr + 9'd3;
    assign raw = {pin_mem[a3], pin_mem[a2], pin_mem[a1], pin_mem[m_addr]};

    always_comb begin
        mem_q = 32'hBAD0_BAD0;
        if (m_en && !m_rw && en_run == cur_lat - 1) begin
            case (m_size)
                2'b00:   mem_q = m_se ? {{24{raw[7]}},  raw[7:0]}  : {24'h0, raw[7:0]};
                2'b01:   mem_q = m_se ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
                default: mem_q = raw;
            endcase
        end
    end

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        en_run  <= m_en ? en_run + 1 : 0;
        if (m_en && m_rw) begin
            pin_mem[m_addr] <= m_wdat[7:0];
            if (m_size != 2'b00) pin_mem[a1] <= m_wdat[15:8];
            if (m_size[1]) begin
                pin_mem[a2] <= m_wdat[23:16];
                pin_mem[a3] <= m_wdat[31:24];
            end
        end
        if ((m_en && prev_en && {m_rw, m_se, m_size, m_addr, m_wdat} != prev_bus) ||
            (m_en && (o_rsp_vld || o_req_rdy)))
            stab_errs <= stab_errs + 1;
        prev_en  <= m_en;
        prev_bus <= {m_rw, m_se, m_size, m_addr, m_wdat};
    end

    // Transaction-level reference image
    logic [7:0] ref_img [512] = '{default: 8'h00};
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic se, input logic [8:0] a);
        logic [31:0] v;
        v = {ref_img[a + 9'd3], ref_img[a + 9'd2], ref_img[a + 9'd1], ref_img[a]};
        if (sz == 2'b00) begin
            v = v & 32'h0000_00FF;
            if (se && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = v & 32'h0000_FFFF;
            if (se && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic txn(input logic w, input logic [1:0] sz, input logic se,
                       input logic [8:0] a, input logic [31:0] wd, input int hold);
        logic        exp_f, f0, unstable;
        logic [31:0] exp_d, rd0;
        int          lat_exp, en_exp, c0, k, en_cnt, stab0, nbytes;
        exp_f   = (sz == 2'b01 && a[0]) || (sz >= 2'b10 && a % 4 != 0);
        exp_d   = (w || exp_f) ? 32'h0 : ref_load(sz, se, a);
        lat_exp = exp_f ? 1 : (w ? 2 : cur_lat + 1);
        en_exp  = exp_f ? 0 : (w ? 1 : cur_lat);
        if (w && !exp_f) begin
            nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
            for (int b = 0; b < nbytes; b++) ref_img[a + 9'(b)] = 8'(wd >> (8 * b));
        end

        repeat ($urandom_range(0, 2)) @(negedge clk);
        req_write = w; req_size = sz; req_se = se; req_addr = a; req_wdat = wd; req_vld = 1'b1;
        k = 0;
        while (!o_req_rdy && k < 20) begin @(negedge clk); k++; end
        chk("req_rdy_idle", 32'(o_req_rdy), 32'd1);
        c0    = cyc;
        stab0 = stab_errs;
        @(negedge clk);
        req_vld = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
        req_se = 1'($urandom); req_addr = 9'($urandom); req_wdat = $urandom;
        en_cnt = 0; k = 0;
        while (!o_rsp_vld && k < 20) begin
            if (m_en) en_cnt++;
            @(negedge clk); k++;
        end
        chk("rsp_latency", 32'(cyc - c0), 32'(lat_exp));
        chk("en_cycles", 32'(en_cnt), 32'(en_exp));
        chk("rsp_rdat", o_rsp_rdat, exp_d);
        chk("rsp_fault", 32'(o_rsp_fault), 32'(exp_f));
        rd0 = o_rsp_rdat; f0 = o_rsp_fault; unstable = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            if (!o_rsp_vld || o_rsp_rdat !== rd0 || o_rsp_fault !== f0 || o_req_rdy || m_en || m_rw)
                unstable = 1'b1;
        end
        chk("rsp_hold", 32'(unstable), 32'd0);
        rsp_rdy = 1'b1;
        @(negedge clk);
        rsp_rdy = 1'b0;
        chk("rsp_release", {28'h0, o_rsp_vld, o_rsp_fault, |o_rsp_rdat, o_req_rdy}, 32'h1);
        chk("mem_stable", 32'(stab_errs - stab0), 32'd0);
    endtask

    logic       r_w;
    logic [1:0] r_sz;
    logic [8:0] r_a;
    logic       seen_rsp;

    initial begin
        rst_n = 1'b0; sel = 1'b0; req_vld = 1'b0; rsp_rdy = 1'b0;
        req_write = 1'b0; req_size = 2'b00; req_se = 1'b0; req_addr = '0; req_wdat = '0;
        repeat (3) @(negedge clk);
        chk("rst_ctl_dut1", {26'h0, if1.rsp_vld, if1.rsp_fault, if1.mem_enable, if1.mem_read_write,
                             if1.mem_se, |if1.mem_size}, 32'h0);
        chk("rst_ctl_dut3", {26'h0, if3.rsp_vld, if3.rsp_fault, if3.mem_enable, if3.mem_read_write,
                             if3.mem_se, |if3.mem_size}, 32'h0);
        chk("rst_rdat", if1.rsp_rdat | if3.rsp_rdat, 32'h0);
        chk("rst_addr", 32'(if1.mem_address | if3.mem_address), 32'h0);
        chk("rst_din", if1.mem_data_in | if3.mem_data_in, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rdy_after_rst", {30'h0, if1.req_rdy, if3.req_rdy}, 32'h3);
        @(negedge clk);

        // READ_LAT=1 directed cases
        txn(1'b1, 2'b10, 1'b0, 9'h010, 32'hDEAD_BEEF, 0);
        txn(1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 0);
        txn(1'b1, 2'b00, 1'b0, 9'h1FF, 32'h0000_0080, 0);
        txn(1'b0, 2'b00, 1'b1, 9'h1FF, 32'h0, 0);
        txn(1'b0, 2'b00, 1'b0, 9'h1FF, 32'h0, 1);
        txn(1'b1, 2'b01, 1'b0, 9'h003, 32'h1234_5678, 0);
        txn(1'b0, 2'b10, 1'b0, 9'h102, 32'h0, 2);
        txn(1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 5);
        txn(1'b1, 2'b01, 1'b0, 9'h1FE, 32'h0000_9ABC, 0);
        txn(1'b0, 2'b01, 1'b1, 9'h1FE, 32'h0, 0);

        // Reset while a store is in ACCESS: enable drops at once, no response, memory untouched
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b10; req_se = 1'b0; req_addr = 9'h020;
        req_wdat = 32'h1234_5678; req_vld = 1'b1;
        @(negedge clk);
        req_vld = 1'b0;
        chk("abort_en_before", 32'(m_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_en_drop", 32'(m_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_rdy", 32'(o_req_rdy), 32'd1);
        seen_rsp = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (o_rsp_vld || m_en) seen_rsp = 1'b1;
        end
        chk("abort_no_rsp", 32'(seen_rsp), 32'd0);
        txn(1'b0, 2'b10, 1'b0, 9'h020, 32'h0, 0);

        // READ_LAT=3 instance
        sel = 1'b1;
        @(negedge clk);
        txn(1'b1, 2'b10, 1'b0, 9'h1FC, 32'hCAFE_F00D, 0);
        txn(1'b0, 2'b10, 1'b0, 9'h1FC, 32'h0, 0);
        txn(1'b1, 2'b11, 1'b0, 9'h1F8, 32'h8765_4321, 0);
        txn(1'b0, 2'b11, 1'b1, 9'h1F8, 32'h0, 3);
        txn(1'b0, 2'b00, 1'b1, 9'h1FF, 32'h0, 0);

        // Randomized traffic on both instances
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            @(negedge clk);
            for (int i = 0; i < 40; i++) begin
                r_w  = 1'($urandom);
                r_sz = 2'($urandom);
                r_a  = ($urandom_range(0, 1) == 0) ? 9'(9'h1E0 + $urandom_range(0, 31)) : 9'($urandom);
                txn(r_w, r_sz, 1'($urandom), r_a, $urandom, $urandom_range(0, 3));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
